mult_key_operand_loader: RTL and testbench

MULT_KEY_OPERAND_LOADER -- requirements
Module: mult_key_operand_loader

---
 rtl/mult_key_operand_loader.sv | 106 ++++++++++
 tb/tb_mult_key_operand_loader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_key_operand_loader.sv
// Operand/key front end for a key-locked multiplier: serial key capture into a
// shadow register with atomic apply, and a one-deep valid/ready operand stage.
module mult_key_operand_loader #(
    parameter int OP_W  = 8,
    parameter int KEY_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_load_i,
    input  logic             key_bit_valid_i,
    input  logic             key_bit_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [OP_W-1:0]  op1_in_i,
    input  logic [OP_W-1:0]  op2_in_i,
    output logic [OP_W-1:0]  op1_o,
    output logic [OP_W-1:0]  op2_o,
    output logic [KEY_W-1:0] keyinput_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             key_ok_o
);
    localparam int CNT_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(KEY_W - 1);

    typedef enum logic [1:0] {NOKEY, LOADING, RUN} state_t;

    state_t           state;
    logic [KEY_W-1:0] shadow;
    logic [KEY_W-1:0] shadow_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic             load_pending;
    logic             out_free;
    logic             accept;

    assign out_free   = ~out_valid_o | out_ready_i;
    assign in_ready_o = (state == RUN) & out_free & ~load_pending;
    assign accept     = in_valid_i & in_ready_o;
    assign shadow_nxt = {shadow[KEY_W-2:0], key_bit_i};

    // Key FSM; keyinput_o is only written from the completed shadow value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= NOKEY;
            shadow       <= '0;
            bit_cnt      <= '0;
            keyinput_o   <= '0;
            key_ok_o     <= 1'b0;
            load_pending <= 1'b0;
        end else begin
            unique case (state)
                NOKEY: begin
                    if (key_load_i) begin
                        state   <= LOADING;
                        shadow  <= '0;
                        bit_cnt <= '0;
                    end
                end
                LOADING: begin
                    if (key_load_i) begin
                        shadow  <= '0;
                        bit_cnt <= '0;
                    end else if (key_bit_valid_i) begin
                        if (bit_cnt == LAST_BIT) begin
                            keyinput_o <= shadow_nxt;
                            key_ok_o   <= 1'b1;
                            shadow     <= '0;
                            bit_cnt    <= '0;
                            state      <= RUN;
                        end else begin
                            shadow  <= shadow_nxt;
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                RUN: begin
                    // A reload waits until the held pair is gone.
                    if ((key_load_i || load_pending) && out_free) begin
                        state        <= LOADING;
                        load_pending <= 1'b0;
                        shadow       <= '0;
                        bit_cnt      <= '0;
                    end else if (key_load_i) begin
                        load_pending <= 1'b1;
                    end
                end
                default: state <= NOKEY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op1_o       <= '0;
            op2_o       <= '0;
            out_valid_o <= 1'b0;
        end else if (accept) begin
            op1_o       <= op1_in_i;
            op2_o       <= op2_in_i;
            out_valid_o <= 1'b1;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mult_key_operand_loader.sv
// Directed bench with a transaction-level model compared every falling edge.
module tb_mult_key_operand_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        key_load = 1'b0;
    logic        kbv = 1'b0;
    logic        kbit = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  op1_in = '0;
    logic [7:0]  op2_in = '0;
    logic [7:0]  op1, op2;
    logic [31:0] key;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        key_ok;

    int checks = 0;
    int failures = 0;

    mult_key_operand_loader #(.OP_W(8), .KEY_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_load_i(key_load), .key_bit_valid_i(kbv), .key_bit_i(kbit),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .op1_in_i(op1_in), .op2_in_i(op2_in),
        .op1_o(op1), .op2_o(op2), .keyinput_o(key),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .key_ok_o(key_ok)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: mode 0 = no key, 1 = collecting bits, 2 = operands flowing.
    int          m_mode = 0;
    int          m_bits = 0;
    logic [31:0] m_acc = '0;
    logic [31:0] m_key = '0;
    logic        m_ok = 1'b0;
    logic        m_pend = 1'b0;
    logic        m_ov = 1'b0;
    logic [7:0]  m_op1 = '0;
    logic [7:0]  m_op2 = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_bits = 0; m_acc = '0; m_key = '0; m_ok = 1'b0;
            m_pend = 1'b0; m_ov = 1'b0; m_op1 = '0; m_op2 = '0;
        end else begin
            bit free;
            free = !m_ov || out_ready;
            if (in_valid && m_mode == 2 && free && !m_pend) begin
                m_ov = 1'b1; m_op1 = op1_in; m_op2 = op2_in;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            if (m_mode == 0) begin
                if (key_load) begin m_mode = 1; m_bits = 0; m_acc = '0; end
            end else if (m_mode == 1) begin
                if (key_load) begin
                    m_bits = 0; m_acc = '0;
                end else if (kbv) begin
                    m_acc = m_acc * 2 + {31'd0, kbit};
                    m_bits++;
                    if (m_bits == 32) begin
                        m_key = m_acc; m_ok = 1'b1; m_mode = 2; m_bits = 0; m_acc = '0;
                    end
                end
            end else begin
                if ((key_load || m_pend) && free) begin
                    m_mode = 1; m_pend = 1'b0; m_bits = 0; m_acc = '0;
                end else if (key_load) begin
                    m_pend = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, (m_mode == 2) && (!m_ov || out_ready) && !m_pend);
        chk("out_valid", out_valid, m_ov);
        chk("op1", op1, m_op1);
        chk("op2", op2, m_op2);
        chk("keyinput", key, m_key);
        chk("key_ok", key_ok, m_ok);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            kbv = 1'b1; kbit = v[31-i];
            step();
            if (gap) begin
                kbv = 1'b0; kbit = ~v[31-i];
                step();
            end
        end
        kbv = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_key"}, key, 0);
        chk({tag, "_key_ok"}, key_ok, 0);
        chk({tag, "_ov"}, out_valid, 0);
        chk({tag, "_op1"}, op1, 0);
        chk({tag, "_op2"}, op2, 0);
        chk({tag, "_ready"}, in_ready, 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) step();
        chk_all_zero("rst");
        rst_n = 1'b1;

        // No key yet: operands refused
        in_valid = 1'b1; op1_in = 8'h11; op2_in = 8'h22; out_ready = 1'b1;
        step(); step();
        chk("nokey_ready", in_ready, 0);
        chk("nokey_ov", out_valid, 0);
        in_valid = 1'b0;

        // First key, MSB first
        key_load = 1'b1; step(); key_load = 1'b0;
        send_bits(32'hA5A55A5A, 31, 1'b0);
        chk("key_before_last", key, 0);
        chk("ok_before_last", key_ok, 0);
        kbv = 1'b1; kbit = 1'b0; step(); kbv = 1'b0;
        chk("key1", key, 32'hA5A55A5A);
        chk("key1_ok", key_ok, 1);

        // Streaming pairs
        in_valid = 1'b1; op1_in = 8'h0F; op2_in = 8'h03;
        chk("run_ready", in_ready, 1);
        step();
        chk("pair_op1", op1, 8'h0F);
        chk("pair_op2", op2, 8'h03);
        chk("pair_ov", out_valid, 1);
        for (int i = 1; i <= 4; i++) begin
            op1_in = 8'(i * 16); op2_in = 8'(i);
            chk("b2b_ready", in_ready, 1);
            step();
            chk("b2b_op1", op1, 8'(i * 16));
            chk("b2b_op2", op2, 8'(i));
        end
        in_valid = 1'b0; step();
        chk("drained_ov", out_valid, 0);

        // Reload requested while a pair is stalled
        in_valid = 1'b1; op1_in = 8'h55; op2_in = 8'hAA; out_ready = 1'b0;
        step();
        in_valid = 1'b0; key_load = 1'b1; step(); key_load = 1'b0;
        chk("pend_ready", in_ready, 0);
        chk("pend_ov", out_valid, 1);
        in_valid = 1'b1; op1_in = 8'h77; op2_in = 8'h88;
        step(); step();
        chk("pend_hold_op1", op1, 8'h55);
        chk("pend_hold_op2", op2, 8'hAA);
        in_valid = 1'b0; out_ready = 1'b1; step();
        chk("reload_ov", out_valid, 0);
        chk("reload_key_kept", key, 32'hA5A55A5A);

        // Aborted load, then clean load; restart wins over a same-cycle bit
        in_valid = 1'b1;
        send_bits(32'hDEADBEEF, 17, 1'b0);
        chk("abort_key_kept", key, 32'hA5A55A5A);
        key_load = 1'b1; kbv = 1'b1; kbit = 1'b1; step(); key_load = 1'b0; kbv = 1'b0;
        send_bits(32'h12345678, 32, 1'b0);
        chk("key2", key, 32'h12345678);
        in_valid = 1'b0;

        // Reload with a pair accepted in the same cycle, then reset mid-load
        in_valid = 1'b1; op1_in = 8'h3C; op2_in = 8'hC3; key_load = 1'b1;
        step();
        in_valid = 1'b0; key_load = 1'b0; out_ready = 1'b0;
        chk("load_ov", out_valid, 1);
        chk("load_op1", op1, 8'h3C);
        send_bits(32'hFFFFFFFF, 10, 1'b0);
        #3 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        step();
        rst_n = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        send_bits(32'hA5A55A5A, 32, 1'b0);
        chk("noload_key", key, 0);
        chk("noload_ok", key_ok, 0);
        chk("noload_ov", out_valid, 0);
        in_valid = 1'b0;

        // Gapped key load
        key_load = 1'b1; step(); key_load = 1'b0;
        send_bits(32'hA5A55A5A, 32, 1'b1);
        chk("gap_key", key, 32'hA5A55A5A);
        chk("gap_ok", key_ok, 1);
        in_valid = 1'b1; op1_in = 8'h0F; op2_in = 8'h03;
        step();
        in_valid = 1'b0;
        chk("final_op1", op1, 8'h0F);
        chk("final_ov", out_valid, 1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
